// File: rtl/link_token_arbiter_pkg.sv
// Shared types and defaults for the two-channel credit-based link arbiter.
// Optional feature: LINK_TOKEN_ARB_ERR_EN enables the sticky credit-overflow error flag.
package link_token_arbiter_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CREDIT_MAX_DEF   = 16;
  localparam int CREDIT_DECIM_DEF = 4;

  // Width needed to hold 0..cmax inclusive.
  function automatic int credit_w(input int cmax);
    return $clog2(cmax + 1);
  endfunction

endpackage

// File: rtl/link_credit_counter.sv
// Per-channel credit counter with token toggle detection; saturates at CREDIT_MAX.
// sat pulses whenever the raw updated value exceeds CREDIT_MAX.
module link_credit_counter
  import link_token_arbiter_pkg::*;
#(
  parameter int CREDIT_MAX   = CREDIT_MAX_DEF,
  parameter int CREDIT_DECIM = CREDIT_DECIM_DEF,
  localparam int CW          = credit_w(CREDIT_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          token,
  input  logic          grant,
  output logic [CW-1:0] credit,
  output logic          sat
);

  logic        token_r;
  logic        ret;
  logic [CW:0] sum;

  // One extra bit so a return on a nearly full counter is visible before clamping.
  always_comb begin
    ret = (token != token_r);
    sum = {1'b0, credit}
        + (ret   ? (CW+1)'(CREDIT_DECIM) : '0)
        - (grant ? (CW+1)'(1)            : '0);
    sat = (sum > (CW+1)'(CREDIT_MAX));
  end

  always_ff @(posedge clk) begin
    token_r <= token;
    if (rst) begin
      credit <= CW'(CREDIT_MAX);
    end else if (sat) begin
      credit <= CW'(CREDIT_MAX);
    end else begin
      credit <= sum[CW-1:0];
    end
  end

endmodule

// File: rtl/link_token_arbiter.sv
// Two-channel round-robin arbiter onto a registered valid/ready link, gated by per-channel credits.
// Optional feature: define LINK_TOKEN_ARB_ERR_EN for a sticky credit-overflow flag on err_o.
module link_token_arbiter
  import link_token_arbiter_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CREDIT_MAX   = CREDIT_MAX_DEF,
  parameter int CREDIT_DECIM = CREDIT_DECIM_DEF,
  localparam int CW          = credit_w(CREDIT_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid_i,
  input  logic [2*DATA_W-1:0] req_data_i,
  output logic [1:0]        req_yumi_o,
  output logic              link_valid_o,
  output logic [DATA_W-1:0] link_data_o,
  output logic              link_ch_o,
  input  logic              link_ready_i,
  input  logic [1:0]        token_i,
  output logic [2*CW-1:0]   credit_o,
  output logic              err_o
);

  // Link handshake: a word moves when link_valid_o && link_ready_i; the output
  // register may reload in that same cycle, and holds while valid && !ready.
  state_t     state;
  state_t     state_nxt;
  logic       last_grant;
  logic       free;
  logic       pri;
  logic [1:0] grant;
  logic [1:0] eligible;
  logic [1:0] sat;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    link_credit_counter #(
      .CREDIT_MAX  (CREDIT_MAX),
      .CREDIT_DECIM(CREDIT_DECIM)
    ) u_credit (
      .clk   (clk),
      .rst   (rst),
      .token (token_i[c]),
      .grant (grant[c]),
      .credit(credit_o[c*CW +: CW]),
      .sat   (sat[c])
    );
    assign eligible[c] = req_valid_i[c] && (credit_o[c*CW +: CW] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = RUN;
    grant     = '0;
    free      = !link_valid_o || link_ready_i;
    pri       = !last_grant;
    if (state == RUN && free) begin
      if (eligible[pri])       grant[pri]  = 1'b1;
      else if (eligible[!pri]) grant[!pri] = 1'b1;
    end
  end

  assign req_yumi_o = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      link_valid_o <= 1'b0;
      link_data_o  <= '0;
      link_ch_o    <= 1'b0;
      last_grant   <= 1'b1;
    end else if (|grant) begin
      link_valid_o <= 1'b1;
      link_data_o  <= grant[1] ? req_data_i[DATA_W +: DATA_W] : req_data_i[0 +: DATA_W];
      link_ch_o    <= grant[1];
      last_grant   <= grant[1];
    end else if (link_ready_i) begin
      link_valid_o <= 1'b0;
    end
  end

`ifdef LINK_TOKEN_ARB_ERR_EN
  logic err;

  always_ff @(posedge clk) begin
    if (rst)       err <= 1'b0;
    else if (|sat) err <= 1'b1;
  end

  assign err_o = err;
`else
  logic unused_sat;

  assign unused_sat = ^sat;
  assign err_o      = 1'b0;
`endif

endmodule

// File: doc/link_token_arbiter.md
LINK_TOKEN_ARBITER -- requirements
Module: link_token_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 Parameters, one per line: name, default, meaning.
- DATA_W, 32, payload width per channel.
- CREDIT_MAX, 16, initial and maximum credits per channel.
- CREDIT_DECIM, 4, credits returned per token toggle.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid_i  in  2  per-channel request valid.
- req_data_i  in  2*DATA_W  per-channel payload; channel c occupies bits [c*DATA_W +: DATA_W].
- req_yumi_o  out  2  one-hot pop; asserted in the cycle a request is captured.
- link_valid_o  out  1  registered link output valid.
- link_data_o  out  DATA_W  registered link payload.
- link_ch_o  out  1  channel id of link_data_o.
- link_ready_i  in  1  link accepts the word when high together with link_valid_o.
- token_i  in  2  per-channel credit-return token from downstream; each toggle returns credits.
- credit_o  out  2*$clog2(CREDIT_MAX+1)  current credit count per channel.
- err_o  out  1  sticky credit-overflow error (see Configuration).

Function
REQ-004 The output register SHALL be "free" when link_valid_o=0, or when link_valid_o=1 and link_ready_i=1.
REQ-005 Channel c SHALL be eligible when req_valid_i[c]=1 and credit[c]>0.
REQ-006 When the output register is free and at least one channel is eligible, the block SHALL grant exactly one channel, raise req_yumi_o for that channel only, and load the granted payload and channel id into the output register.
REQ-007 A granted word SHALL appear on link_valid_o/link_data_o in the cycle after the grant (latency 1); a request presented to a free register SHALL never wait longer than 1 cycle for capture unless it is ineligible or loses arbitration.
REQ-008 Arbitration SHALL be round-robin: a last_grant pointer gives priority to the channel other than the one last granted, and the pointer SHALL update only on a grant.
REQ-009 While link_valid_o=1 and link_ready_i=0, link_valid_o, link_data_o and link_ch_o SHALL be held stable, and req_yumi_o SHALL be 0.
REQ-010 Back-to-back operation: when link_ready_i=1, a new grant SHALL be captured in the same cycle the current word drains, sustaining 1 word per cycle.
REQ-011 Token edge detection: a registered copy token_r SHALL be kept; a return event for channel c is token_i[c] != token_r[c].
REQ-012 Credit update per channel in each cycle SHALL be credit + (return ? CREDIT_DECIM : 0) - (grant ? 1 : 0), computed at width $clog2(CREDIT_MAX+1)+1; a return and a grant in the same cycle SHALL both apply.
REQ-013 If the updated credit value exceeds CREDIT_MAX, the credit SHALL saturate at CREDIT_MAX; credit SHALL never be decremented below 0, since no grant is made at credit 0.
REQ-014 FSM states SHALL be INIT and RUN; INIT is entered on reset and lasts one cycle, with no grants issued; INIT->RUN occurs unconditionally.

Reset
REQ-015 When rst=1, the block SHALL apply the following on the next clk edge:
- link_valid_o=0, link_data_o=0, link_ch_o=0, req_yumi_o=0.
- credit[c]=CREDIT_MAX, last_grant=1 (so channel 0 wins first), err_o=0, state=INIT.
- token_r<=token_i, so no spurious return is seen after reset.
REQ-016 Reset asserted while link_valid_o=1 SHALL discard the pending word without handshake.

Configuration
REQ-017 Macro LINK_TOKEN_ARB_ERR_EN: when defined, err_o SHALL be set on any saturation event per REQ-013 and held until reset; when undefined, err_o SHALL be tied to 0 and no error logic SHALL be present.

Structure
REQ-018 A shared package SHALL hold the FSM state enum (INIT, RUN), the credit-width localparam function, and the CREDIT_MAX and CREDIT_DECIM defaults.
REQ-019 The per-channel credit counter and token edge detector SHALL be one sub-module, link_credit_counter, instantiated twice.

Verification
REQ-020 Reset then both channels valid, link_ready_i=1 -> grants alternate ch0, ch1, ch0, ...; first link_valid_o appears 2 cycles after rst deasserts (1 INIT cycle, then latency 1).
REQ-021 Only ch0 valid, no token toggles, link_ready_i=1 -> exactly 16 words sent, then req_yumi_o=0 and credit_o[ch0]=0.
REQ-022 Ch0 at credit 0, toggle token_i[0] once -> credit_o[ch0]=4 the next cycle and 4 further words flow.
REQ-023 link_ready_i=0 for 5 cycles with a word pending -> link_data_o stable, req_yumi_o=0 and credits unchanged for all 5 cycles.
REQ-024 Ch1 at credit 14: toggle token_i[1] with no grant -> credit 16, and err_o=1 only with LINK_TOKEN_ARB_ERR_EN defined; toggle together with a grant -> 14+4-1=17 saturates to 16.
REQ-025 Assert rst mid-stream with link_valid_o=1 -> next cycle link_valid_o=0, both credits=16, and no spurious credit return even if token_i differs from its pre-reset value.
